bnn_conv_multik: RTL and testbench

- Parametrised successor to the single-kernel binary 3x3 convolution engine.
- Streams binarised image rows from the input SRAM through a 3-row line buffer.
- Applies NUM_K 3x3 XNOR/popcount kernels held in registers, loaded from weight memory at start.
- Writes one thresholded output row per kernel per output row to the output SRAM; processes chained frames until a terminator header.

---
 rtl/bnn_pkg.sv | 27 ++
 rtl/bnn_row_xnor_popcount.sv | 24 ++
 rtl/bnn_conv_multik.sv | 175 +++++++++++++++++
 tb/tb_bnn_conv_multik.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared types, constants and helpers for the multi-kernel binary 3x3 convolution engine.
package bnn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        HDR_REQ,
        HDR_CAP,
        ROW_REQ,
        ROW_CAP,
        WRITE,
        DONE
    } state_t;

    localparam logic [15:0] HDR_TERM  = 16'h00FF;
    localparam int          KERN_BITS = 9;

    function automatic logic [3:0] popcount9(input logic [KERN_BITS-1:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < KERN_BITS; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/bnn_row_xnor_popcount.sv
// One output row of a binary 3x3 convolution: XNOR a 9-bit kernel against a
// sliding 3x3 window of three rows and threshold the match count per column.
module bnn_row_xnor_popcount
    import bnn_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int THRESH = 4
) (
    input  logic [DATA_W-1:0]    top_i,
    input  logic [DATA_W-1:0]    mid_i,
    input  logic [DATA_W-1:0]    bot_i,
    input  logic [KERN_BITS-1:0] kern_i,
    output logic [DATA_W-3:0]    res_o
);

    // Kernel bit 0 pairs with top[j], bit 3 with mid[j], bit 6 with bot[j].
    always_comb begin
        res_o = '0;
        for (int j = 0; j < DATA_W - 2; j++) begin
            res_o[j] = (popcount9(~(kern_i ^ {bot_i[j+:3], mid_i[j+:3], top_i[j+:3]})) > 4'(THRESH));
        end
    end

endmodule

// File: rtl/bnn_conv_multik.sv
// Streams framed binary image rows through a 3-row line buffer and writes one
// thresholded convolution row per kernel, kernel-interleaved, to the output SRAM.
module bnn_conv_multik
    import bnn_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12,
    parameter int NUM_K  = 4,
    parameter int THRESH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] dut_sram_read_address,
    input  logic [DATA_W-1:0] sram_dut_read_data,
    output logic [ADDR_W-1:0] dut_sram_write_address,
    output logic [DATA_W-1:0] dut_sram_write_data,
    output logic              wr_enable,
    output logic [ADDR_W-1:0] dut_wmem_read_address,
    input  logic [DATA_W-1:0] wmem_dut_read_data
);

    state_t               state_q;
    logic [ADDR_W-1:0]    rdPtr_q;
    logic [ADDR_W-1:0]    wrPtr_q;
    logic [ADDR_W-1:0]    wmemAddr_q;
    logic [ADDR_W-1:0]    wrAddr_q;
    logic [DATA_W-1:0]    wrData_q;
    logic [DATA_W-1:0]    rowsLeft_q;
    logic [DATA_W-1:0]    rowsLeft_d;
    logic [DATA_W-1:0]    top_q;
    logic [DATA_W-1:0]    mid_q;
    logic [DATA_W-1:0]    bot_q;
    logic [1:0]           rowCnt_q;
    logic [1:0]           rowCnt_d;
    logic [3:0]           loadCnt_q;
    logic [3:0]           writeK_q;
    logic [KERN_BITS-1:0] kern_q [NUM_K];
    logic [KERN_BITS-1:0] kernSel;
    logic [DATA_W-3:0]    convRow;
    logic                 wrEn_q;
    logic                 done_q;
    logic                 unusedWmemBits;

    assign unusedWmemBits = ^wmem_dut_read_data[DATA_W-1:KERN_BITS];

    assign busy                   = (state_q != IDLE);
    assign done                   = done_q;
    assign wr_enable              = wrEn_q;
    assign dut_sram_read_address  = rdPtr_q;
    assign dut_sram_write_address = wrAddr_q;
    assign dut_sram_write_data    = wrData_q;
    assign dut_wmem_read_address  = wmemAddr_q;

    assign rowsLeft_d = rowsLeft_q - 1'b1;
    assign rowCnt_d   = (rowCnt_q == 2'd3) ? 2'd3 : rowCnt_q + 2'd1;

    // A single convolver is shared by all kernels; WRITE steps through them.
    always_comb begin
        kernSel = '0;
        for (int k = 0; k < NUM_K; k++) begin
            if (writeK_q == 4'(k)) begin
                kernSel = kern_q[k];
            end
        end
    end

    bnn_row_xnor_popcount #(
        .DATA_W (DATA_W),
        .THRESH (THRESH)
    ) u_conv (
        .top_i  (top_q),
        .mid_i  (mid_q),
        .bot_i  (bot_q),
        .kern_i (kernSel),
        .res_o  (convRow)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rdPtr_q    <= '0;
            wrPtr_q    <= '0;
            wmemAddr_q <= '0;
            wrAddr_q   <= '0;
            wrData_q   <= '0;
            rowsLeft_q <= '0;
            top_q      <= '0;
            mid_q      <= '0;
            bot_q      <= '0;
            rowCnt_q   <= '0;
            loadCnt_q  <= '0;
            writeK_q   <= '0;
            wrEn_q     <= 1'b0;
            done_q     <= 1'b0;
            for (int k = 0; k < NUM_K; k++) begin
                kern_q[k] <= '0;
            end
        end else begin
            wrEn_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (run) begin
                        state_q    <= LOAD_W;
                        rdPtr_q    <= '0;
                        wrPtr_q    <= '0;
                        rowCnt_q   <= '0;
                        wmemAddr_q <= '0;
                        loadCnt_q  <= '0;
                    end
                end
                LOAD_W: begin
                    // Weight data lags its address by one cycle, so kernel k lands at count k+1.
                    for (int k = 0; k < NUM_K; k++) begin
                        if (loadCnt_q == 4'(k + 1)) begin
                            kern_q[k] <= wmem_dut_read_data[KERN_BITS-1:0];
                        end
                    end
                    if (loadCnt_q < 4'(NUM_K - 1)) begin
                        wmemAddr_q <= wmemAddr_q + 1'b1;
                    end
                    if (loadCnt_q == 4'(NUM_K)) begin
                        state_q <= HDR_REQ;
                    end else begin
                        loadCnt_q <= loadCnt_q + 4'd1;
                    end
                end
                HDR_REQ: state_q <= HDR_CAP;
                HDR_CAP: begin
                    rdPtr_q <= rdPtr_q + 1'b1;
                    if (sram_dut_read_data == DATA_W'(HDR_TERM)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        rowsLeft_q <= sram_dut_read_data;
                        rowCnt_q   <= '0;
                        state_q    <= (sram_dut_read_data == '0) ? HDR_REQ : ROW_REQ;
                    end
                end
                ROW_REQ: state_q <= ROW_CAP;
                ROW_CAP: begin
                    top_q      <= mid_q;
                    mid_q      <= bot_q;
                    bot_q      <= sram_dut_read_data;
                    rdPtr_q    <= rdPtr_q + 1'b1;
                    rowsLeft_q <= rowsLeft_d;
                    rowCnt_q   <= rowCnt_d;
                    if (rowCnt_d == 2'd3) begin
                        state_q  <= WRITE;
                        writeK_q <= '0;
                    end else begin
                        state_q <= (rowsLeft_d != '0) ? ROW_REQ : HDR_REQ;
                    end
                end
                WRITE: begin
                    wrEn_q   <= 1'b1;
                    wrAddr_q <= wrPtr_q;
                    wrData_q <= {2'b00, convRow};
                    wrPtr_q  <= wrPtr_q + 1'b1;
                    if (writeK_q == 4'(NUM_K - 1)) begin
                        state_q <= (rowsLeft_q != '0) ? ROW_REQ : HDR_REQ;
                    end else begin
                        writeK_q <= writeK_q + 4'd1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_conv_multik.sv
// Scoreboard bench for bnn_conv_multik: a frame-level reference model queues the
// expected output words, and a negedge monitor compares every write against them.
module tb_bnn_conv_multik;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 12;
    localparam int NUM_K     = 4;
    localparam int THRESH    = 4;
    localparam int MEM_DEPTH = 1 << ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clk;
    logic              reset;
    logic              run;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] dut_sram_read_address;
    logic [DATA_W-1:0] sram_dut_read_data;
    logic [ADDR_W-1:0] dut_sram_write_address;
    logic [DATA_W-1:0] dut_sram_write_data;
    logic              wr_enable;
    logic [ADDR_W-1:0] dut_wmem_read_address;
    logic [DATA_W-1:0] wmem_dut_read_data;

    logic [DATA_W-1:0] sramMem [MEM_DEPTH];
    logic [DATA_W-1:0] wmemMem [MEM_DEPTH];
    logic [8:0]        kernList [NUM_K];
    int                frameN[$];
    logic [DATA_W-1:0] rowList[$];
    wr_t               expQ[$];
    int                checks = 0;
    int                errors = 0;

    bnn_conv_multik #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NUM_K  (NUM_K),
        .THRESH (THRESH)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .run                    (run),
        .busy                   (busy),
        .done                   (done),
        .dut_sram_read_address  (dut_sram_read_address),
        .sram_dut_read_data     (sram_dut_read_data),
        .dut_sram_write_address (dut_sram_write_address),
        .dut_sram_write_data    (dut_sram_write_data),
        .wr_enable              (wr_enable),
        .dut_wmem_read_address  (dut_wmem_read_address),
        .wmem_dut_read_data     (wmem_dut_read_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Both memories answer one cycle after the address.
    always @(posedge clk) begin
        sram_dut_read_data <= sramMem[dut_sram_read_address];
        wmem_dut_read_data <= wmemMem[dut_wmem_read_address];
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] modelConv(input logic [8:0] k, input logic [DATA_W-1:0] t,
                                                    input logic [DATA_W-1:0] m, input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] res;
        int pop;
        res = '0;
        for (int j = 0; j < DATA_W - 2; j++) begin
            pop = 0;
            for (int i = 0; i < 3; i++) begin
                pop += (k[i] == t[j+i]) ? 1 : 0;
                pop += (k[3+i] == m[j+i]) ? 1 : 0;
                pop += (k[6+i] == b[j+i]) ? 1 : 0;
            end
            res[j] = (pop > THRESH);
        end
        return res;
    endfunction

    // Scoreboard monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        wr_t e;
        if (reset && wr_enable) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedWrite addr=%0h data=%0h required=none", dut_sram_write_address, dut_sram_write_data);
            end else begin
                e = expQ.pop_front();
                checkOutput("wrAddr", int'(dut_sram_write_address), int'(e.addr));
                checkOutput("wrData", int'(dut_sram_write_data), int'(e.data));
            end
        end
    end

    // Lay out kernels and framed rows in memory, queue expected writes, return the run length.
    task automatic buildProgram(output int expCycles);
        int addr;
        int wp;
        int rowIdx;
        int n;
        logic [DATA_W-1:0] rows[$];
        addr = 0;
        wp = 0;
        rowIdx = 0;
        for (int k = 0; k < NUM_K; k++) begin
            wmemMem[k] = {7'($urandom), kernList[k]};
        end
        expCycles = NUM_K + 1;
        foreach (frameN[f]) begin
            n = frameN[f];
            sramMem[addr] = DATA_W'(n);
            addr++;
            rows.delete();
            for (int r = 0; r < n; r++) begin
                sramMem[addr] = rowList[rowIdx];
                rows.push_back(rowList[rowIdx]);
                addr++;
                rowIdx++;
            end
            expCycles += 2 + 2 * n;
            if (n >= 3) begin
                expCycles += (n - 2) * NUM_K;
                for (int o = 0; o <= n - 3; o++) begin
                    for (int k = 0; k < NUM_K; k++) begin
                        expQ.push_back({ADDR_W'(wp), modelConv(kernList[k], rows[o], rows[o+1], rows[o+2])});
                        wp++;
                    end
                end
            end
        end
        sramMem[addr] = 16'h00FF;
        expCycles += 2;
    endtask

    task automatic applyStimulus(input bit extraRun);
        int expCycles;
        int cyc;
        buildProgram(expCycles);
        @(negedge clk);
        run = 1'b1;
        @(posedge clk);
        #1 run = 1'b0;
        cyc = 0;
        while (cyc < expCycles + 50) begin
            @(negedge clk);
            if (cyc == 0) begin
                checkOutput("busyAfterRun", int'(busy), 1);
                checkOutput("wmemAddrStart", int'(dut_wmem_read_address), 0);
                checkOutput("sramAddrStart", int'(dut_sram_read_address), 0);
            end
            if (done) break;
            run = extraRun && cyc >= 3 && cyc < 6;
            @(posedge clk);
            cyc++;
        end
        run = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL doneTimeout cycles=%0d required=%0d", cyc, expCycles);
        end else begin
            checkOutput("latency", cyc, expCycles);
        end
        @(negedge clk);
        checkOutput("busyAfterDone", int'(busy), 0);
        checkOutput("donePulseWidth", int'(done), 0);
        checkOutput("pendingWrites", expQ.size(), 0);
        expQ.delete();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "Busy"}, int'(busy), 0);
        checkOutput({tag, "Done"}, int'(done), 0);
        checkOutput({tag, "WrEn"}, int'(wr_enable), 0);
        checkOutput({tag, "RdAddr"}, int'(dut_sram_read_address), 0);
        checkOutput({tag, "WrAddr"}, int'(dut_sram_write_address), 0);
        checkOutput({tag, "WrData"}, int'(dut_sram_write_data), 0);
        checkOutput({tag, "WmemAddr"}, int'(dut_wmem_read_address), 0);
    endtask

    // Start a long frame, then pull reset while the kernel writes are streaming.
    task automatic abortRun();
        int expCycles;
        int cyc;
        buildProgram(expCycles);
        @(negedge clk);
        run = 1'b1;
        @(posedge clk);
        #1 run = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!wr_enable && cyc < 200);
        if (!wr_enable) begin
            checks++;
            errors++;
            $display("[TB] FAIL writeTimeout cycles=%0d required=<200", cyc);
        end
        @(posedge clk);
        #2 reset = 1'b0;
        #1 checkAllZero("abort");
        expQ.delete();
        repeat (2) @(negedge clk);
        checkOutput("abortHoldWrEn", int'(wr_enable), 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("abortIdleBusy", int'(busy), 0);
    endtask

    task automatic randomRows(input int count);
        for (int r = 0; r < count; r++) begin
            case ($urandom_range(0, 3))
                0:       rowList.push_back(DATA_W'($urandom) & DATA_W'($urandom));
                1:       rowList.push_back(DATA_W'($urandom) | DATA_W'($urandom));
                default: rowList.push_back(DATA_W'($urandom));
            endcase
        end
    endtask

    initial begin
        int total;
        run = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < MEM_DEPTH; i++) begin
            sramMem[i] = '0;
            wmemMem[i] = '0;
        end
        #3 reset = 1'b0;
        #1 checkAllZero("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        kernList = '{9'h1FF, 9'h000, 9'h0AA, 9'h155};
        frameN.delete(); rowList.delete();
        frameN.push_back(3);
        rowList = {16'hFFFF, 16'hFFFF, 16'hFFFF};
        applyStimulus(1'b0);

        frameN.delete(); rowList.delete();
        frameN.push_back(3);
        rowList = {16'hFFFF, 16'h0003, 16'h0000};
        applyStimulus(1'b0);

        kernList = '{9'h000, 9'h1FF, 9'h1C7, 9'h038};
        frameN.delete(); rowList.delete();
        frameN.push_back(3);
        rowList = {16'h0000, 16'h0000, 16'h0000};
        applyStimulus(1'b0);

        for (int k = 0; k < NUM_K; k++) kernList[k] = 9'($urandom);
        frameN.delete(); rowList.delete();
        frameN = {2, 3, 0, 5};
        randomRows(10);
        applyStimulus(1'b1);

        frameN.delete(); rowList.delete();
        frameN.push_back(6);
        randomRows(6);
        abortRun();

        kernList = '{9'h1FF, 9'h000, 9'h1FF, 9'h000};
        frameN.delete(); rowList.delete();
        frameN.push_back(4);
        rowList = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        applyStimulus(1'b0);

        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < NUM_K; k++) kernList[k] = 9'($urandom);
            frameN.delete(); rowList.delete();
            total = 0;
            for (int f = 0; f < $urandom_range(1, 4); f++) begin
                frameN.push_back($urandom_range(0, 7));
                total += frameN[f];
            end
            randomRows(total);
            applyStimulus(t[0]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
